// File: rtl/alu_disp_pkg.sv
// Shared types and segment constants for the clocked ALU display.
// Segments are active-low, bit 0 = a ... bit 6 = g.
package alu_disp_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_MUL = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_CONV  = 2'b01,
    ST_WRITE = 2'b10
  } state_t;

  localparam logic [6:0] SEG_ZERO  = 7'b1000000;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // BCD-to-7-segment decoder; non-decimal codes blank the digit.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/bcd_dd_seq.sv
// Sequential double-dabble converter: load clears the BCD field, each shift
// performs one add-3/shift step; it stops by itself after BW steps and holds.
module bcd_dd_seq #(
  parameter int BW = 4,
  parameter int ND = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              shift,
  input  logic [BW-1:0]     bin_in,
  output logic [4*ND-1:0]   bcd_out
);
  localparam int CW = $clog2(BW + 1);

  logic [4*ND+BW-1:0] sr_reg;
  logic [CW-1:0]      left_reg;
  logic [4*ND-1:0]    adj_bcd;
  logic [4*ND+BW-1:0] sr_next;

  genvar gi;
  generate
    for (gi = 0; gi < ND; gi++) begin : g_adj
      logic [3:0] nib;
      assign nib = sr_reg[BW+4*gi +: 4];
      assign adj_bcd[4*gi +: 4] = (nib >= 4'd5) ? nib + 4'd3 : nib;
    end
  endgenerate

  assign sr_next = {adj_bcd, sr_reg[BW-1:0]} << 1;
  assign bcd_out = sr_reg[4*ND+BW-1:BW];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_reg   <= '0;
      left_reg <= '0;
    end else if (load) begin
      sr_reg   <= {{(4*ND){1'b0}}, bin_in};
      left_reg <= CW'(BW);
    end else if (shift && left_reg != '0) begin
      sr_reg   <= sr_next;
      left_reg <= left_reg - 1'b1;
    end
  end

endmodule

// File: rtl/alu_bcd_display_seq.sv
// Clocked ALU with sequential BCD conversion and registered 7-segment outputs.
// Optional macro ALU_DISP_SIGNED_SUB_EN shows SUB with A<B as minus + magnitude.
module alu_bcd_display_seq
  import alu_disp_pkg::*;
#(
  parameter int W   = 4,
  parameter int OPD = 2,
  parameter int RSD = 3
) (
  input  logic               CLOCK_50,
  input  logic               RESET_N,
  input  logic [2*W+1:0]     SW,
  output logic [7*OPD-1:0]   HEX_A,
  output logic [7*OPD-1:0]   HEX_B,
  output logic [7*RSD-1:0]   HEX_Y,
  output logic               BUSY,
  output logic               DONE
);
  localparam int RW = 2 * W;
  localparam int CW = $clog2(RW + 1);

  logic [2*W+1:0] sw_m_reg, sw_s_reg, sw_c_reg;
  state_t         state_reg;
  logic [CW-1:0]  cnt_reg;

  logic [W-1:0]   a_s, b_s;
  op_t            op_s;
  logic [RW-1:0]  y_next;
  logic           neg_next;
  logic           commit;

  logic [4*OPD-1:0] bcd_a, bcd_b;
  logic [4*RSD-1:0] bcd_y;
  logic [7*OPD-1:0] seg_a_next, seg_b_next;
  logic [7*RSD-1:0] seg_y_next;

`ifdef ALU_DISP_SIGNED_SUB_EN
  logic neg_reg;
`endif

  assign a_s    = sw_s_reg[W-1:0];
  assign b_s    = sw_s_reg[2*W-1:W];
  assign op_s   = op_t'(sw_s_reg[2*W+1:2*W]);
  assign commit = (state_reg == ST_IDLE) && (sw_s_reg != sw_c_reg);

  always_comb begin
    y_next   = '0;
    neg_next = 1'b0;
    case (op_s)
      OP_ADD: y_next = RW'(a_s) + RW'(b_s);
      OP_SUB: begin
`ifdef ALU_DISP_SIGNED_SUB_EN
        if (a_s < b_s) begin
          y_next   = RW'(b_s) - RW'(a_s);
          neg_next = 1'b1;
        end else begin
          y_next = RW'(a_s) - RW'(b_s);
        end
`else
        y_next = RW'(a_s) - RW'(b_s);
`endif
      end
      OP_AND: y_next = RW'(a_s & b_s);
      OP_MUL: y_next = RW'(a_s) * RW'(b_s);
      default: y_next = '0;
    endcase
  end

  bcd_dd_seq #(.BW(W), .ND(OPD)) u_bcd_a (
    .clk(CLOCK_50), .rst_n(RESET_N), .load(commit),
    .shift(state_reg == ST_CONV), .bin_in(a_s), .bcd_out(bcd_a)
  );

  bcd_dd_seq #(.BW(W), .ND(OPD)) u_bcd_b (
    .clk(CLOCK_50), .rst_n(RESET_N), .load(commit),
    .shift(state_reg == ST_CONV), .bin_in(b_s), .bcd_out(bcd_b)
  );

  bcd_dd_seq #(.BW(RW), .ND(RSD)) u_bcd_y (
    .clk(CLOCK_50), .rst_n(RESET_N), .load(commit),
    .shift(state_reg == ST_CONV), .bin_in(y_next), .bcd_out(bcd_y)
  );

  genvar gi;
  generate
    for (gi = 0; gi < OPD; gi++) begin : g_seg_ab
      assign seg_a_next[7*gi +: 7] = seg7(bcd_a[4*gi +: 4]);
      assign seg_b_next[7*gi +: 7] = seg7(bcd_b[4*gi +: 4]);
    end
    for (gi = 0; gi < RSD; gi++) begin : g_seg_y
      if (gi == RSD - 1) begin : g_msd
`ifdef ALU_DISP_SIGNED_SUB_EN
        assign seg_y_next[7*gi +: 7] = neg_reg ? SEG_MINUS : seg7(bcd_y[4*gi +: 4]);
`else
        assign seg_y_next[7*gi +: 7] = seg7(bcd_y[4*gi +: 4]);
`endif
      end else begin : g_lsd
        assign seg_y_next[7*gi +: 7] = seg7(bcd_y[4*gi +: 4]);
      end
    end
  endgenerate

  // HEX registers are only written in WRITE, so partial BCD never shows.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      sw_m_reg  <= '0;
      sw_s_reg  <= '0;
      sw_c_reg  <= '0;
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      HEX_A     <= {OPD{SEG_ZERO}};
      HEX_B     <= {OPD{SEG_ZERO}};
      HEX_Y     <= {RSD{SEG_ZERO}};
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
`ifdef ALU_DISP_SIGNED_SUB_EN
      neg_reg   <= 1'b0;
`endif
    end else begin
      sw_m_reg <= SW;
      sw_s_reg <= sw_m_reg;
      DONE     <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (commit) begin
            sw_c_reg  <= sw_s_reg;
            cnt_reg   <= CW'(RW);
            BUSY      <= 1'b1;
            state_reg <= ST_CONV;
`ifdef ALU_DISP_SIGNED_SUB_EN
            neg_reg   <= neg_next;
`endif
          end
        end
        ST_CONV: begin
          cnt_reg <= cnt_reg - 1'b1;
          if (cnt_reg <= CW'(1)) state_reg <= ST_WRITE;
        end
        ST_WRITE: begin
          HEX_A     <= seg_a_next;
          HEX_B     <= seg_b_next;
          HEX_Y     <= seg_y_next;
          DONE      <= 1'b1;
          BUSY      <= 1'b0;
          state_reg <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

`ifndef ALU_DISP_SIGNED_SUB_EN
  logic unused_neg;
  assign unused_neg = neg_next;
`endif

endmodule
